// File: rtl/router_port_arbiter.sv
// Three-input, three-output router port arbiter with per-output round-robin and starvation override.
// Requests are sampled each edge; grant/sel/fail are registered one-cycle results of that arbitration.
module router_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_x,
    input  logic       valid_y,
    input  logic       valid_local,
    input  logic [1:0] dest_x,
    input  logic [1:0] dest_y,
    input  logic [1:0] dest_local,
    input  logic       next_full_x,
    input  logic       next_full_y,
    input  logic       next_full_local,
    output logic       grant_x,
    output logic       grant_y,
    output logic       grant_local,
    output logic [1:0] sel_x,
    output logic [1:0] sel_y,
    output logic [1:0] sel_local,
    output logic [2:0] fail,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARB   = 2'b01,
        STALL = 2'b10
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     fsm_q;
    state_t     fsm_p0;
    logic [1:0] ptr_x, ptr_y, ptr_local;
    logic [2:0] cnt_x, cnt_y, cnt_local;

    logic [2:0] granted;
    logic [2:0] elig_p0;
    logic [2:0] starve_p0;
    logic [2:0] req_x_p0, req_y_p0, req_local_p0;
    logic [1:0] win_x_p0, win_y_p0, win_local_p0;
    logic [2:0] gnt_p0;
    logic [2:0] fail_p0;

    // First set bit of cand scanning from index ptr upward (wrapping); returns index+1, or 0 if none.
    function automatic logic [1:0] rr_pick(input logic [2:0] cand, input logic [1:0] ptr);
        logic [2:0] rot;
        logic [1:0] off;
        logic [2:0] pos;
        case (ptr)
            2'd1:    rot = {cand[0], cand[2], cand[1]};
            2'd2:    rot = {cand[1], cand[0], cand[2]};
            default: rot = cand;
        endcase
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else             off = 2'd2;
        pos = {1'b0, ptr} + {1'b0, off};
        if (pos >= 3'd3) pos = pos - 3'd3;
        return (rot == 3'b000) ? 2'b00 : pos[1:0] + 2'd1;
    endfunction

    function automatic logic [1:0] arbitrate(input logic [2:0] req, input logic [2:0] starve,
                                             input logic [1:0] ptr, input logic full);
        if (full || req == 3'b000) return 2'b00;
        return rr_pick(((req & starve) != 3'b000) ? (req & starve) : req, ptr);
    endfunction

    function automatic logic [1:0] ptr_after(input logic [1:0] win, input logic [1:0] ptr);
        if (win == 2'b00) return ptr;
        return (win == 2'b11) ? 2'd0 : win;
    endfunction

    function automatic logic [2:0] cnt_after(input logic lost, input logic [2:0] cnt);
        if (!lost) return 3'd0;
        return (cnt >= LIMIT) ? LIMIT : cnt + 3'd1;
    endfunction

    function automatic logic [2:0] win_onehot(input logic [1:0] win);
        if (win == 2'b00) return 3'b000;
        return 3'b001 << (win - 2'd1);
    endfunction

    assign granted = {grant_local, grant_y, grant_x};

    // An input granted last cycle is popping its flit, so it sits out this arbitration.
    assign elig_p0 = {valid_local, valid_y, valid_x}
                   & {dest_local != 2'b00, dest_y != 2'b00, dest_x != 2'b00}
                   & ~granted;

    assign starve_p0 = {cnt_local == LIMIT, cnt_y == LIMIT, cnt_x == LIMIT};

    assign req_x_p0     = elig_p0 & {dest_local == 2'b01, dest_y == 2'b01, dest_x == 2'b01};
    assign req_y_p0     = elig_p0 & {dest_local == 2'b10, dest_y == 2'b10, dest_x == 2'b10};
    assign req_local_p0 = elig_p0 & {dest_local == 2'b11, dest_y == 2'b11, dest_x == 2'b11};

    assign win_x_p0     = arbitrate(req_x_p0, starve_p0, ptr_x, next_full_x);
    assign win_y_p0     = arbitrate(req_y_p0, starve_p0, ptr_y, next_full_y);
    assign win_local_p0 = arbitrate(req_local_p0, starve_p0, ptr_local, next_full_local);

    assign gnt_p0  = win_onehot(win_x_p0) | win_onehot(win_y_p0) | win_onehot(win_local_p0);
    assign fail_p0 = elig_p0 & ~gnt_p0;

    // With eligible requests, zero grants can only mean every requested output was full.
    always_comb begin
        fsm_p0 = fsm_q;
        if (elig_p0 == 3'b000)      fsm_p0 = IDLE;
        else if (fsm_q == IDLE)     fsm_p0 = ARB;
        else if (gnt_p0 != 3'b000)  fsm_p0 = ARB;
        else                        fsm_p0 = STALL;
    end

    // stage p0 -> registered outputs and arbitration state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_x     <= 1'b0;
            grant_y     <= 1'b0;
            grant_local <= 1'b0;
            sel_x       <= 2'b00;
            sel_y       <= 2'b00;
            sel_local   <= 2'b00;
            fail        <= 3'b000;
            fsm_q       <= IDLE;
            ptr_x       <= 2'd0;
            ptr_y       <= 2'd0;
            ptr_local   <= 2'd0;
            cnt_x       <= 3'd0;
            cnt_y       <= 3'd0;
            cnt_local   <= 3'd0;
        end else begin
            grant_x     <= gnt_p0[0];
            grant_y     <= gnt_p0[1];
            grant_local <= gnt_p0[2];
            sel_x       <= win_x_p0;
            sel_y       <= win_y_p0;
            sel_local   <= win_local_p0;
            fail        <= fail_p0;
            fsm_q       <= fsm_p0;
            ptr_x       <= ptr_after(win_x_p0, ptr_x);
            ptr_y       <= ptr_after(win_y_p0, ptr_y);
            ptr_local   <= ptr_after(win_local_p0, ptr_local);
            cnt_x       <= cnt_after(fail_p0[0], cnt_x);
            cnt_y       <= cnt_after(fail_p0[1], cnt_y);
            cnt_local   <= cnt_after(fail_p0[2], cnt_local);
        end
    end

    assign state = fsm_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_router_port_arbiter;

    localparam int LIMIT = 2;

    logic       clk;
    logic       rst_n;
    logic       valid_x, valid_y, valid_local;
    logic [1:0] dest_x, dest_y, dest_local;
    logic       next_full_x, next_full_y, next_full_local;
    logic       grant_x, grant_y, grant_local;
    logic [1:0] sel_x, sel_y, sel_local;
    logic [2:0] fail;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    router_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_x(valid_x), .valid_y(valid_y), .valid_local(valid_local),
        .dest_x(dest_x), .dest_y(dest_y), .dest_local(dest_local),
        .next_full_x(next_full_x), .next_full_y(next_full_y), .next_full_local(next_full_local),
        .grant_x(grant_x), .grant_y(grant_y), .grant_local(grant_local),
        .sel_x(sel_x), .sel_y(sel_y), .sel_local(sel_local),
        .fail(fail), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = X, 1 = Y, 2 = local; output o serves dest code o+1.
    int  m_ptr[3];
    int  m_cnt[3];
    bit  m_grant[3];
    int  m_sel[3];
    bit  m_fail[3];
    int  m_state;
    bit  model_ready = 1'b0;
    int  vin[3], din[3], fin[3];
    bit  el[3], g[3];
    int  order[$];
    int  win, nel, ng, idx;

    always @(posedge clk) begin
        model_ready = 1'b1;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_ptr[i] = 0; m_cnt[i] = 0; m_grant[i] = 0; m_sel[i] = 0; m_fail[i] = 0;
            end
            m_state = 0;
        end else begin
            vin = '{int'(valid_x), int'(valid_y), int'(valid_local)};
            din = '{int'(dest_x), int'(dest_y), int'(dest_local)};
            fin = '{int'(next_full_x), int'(next_full_y), int'(next_full_local)};
            nel = 0;
            ng = 0;
            for (int i = 0; i < 3; i++) begin
                el[i] = (vin[i] != 0) && (din[i] != 0) && !m_grant[i];
                if (el[i]) nel++;
                g[i] = 1'b0;
            end
            for (int o = 0; o < 3; o++) begin
                m_sel[o] = 0;
                order.delete();
                if (fin[o] == 0) begin
                    for (int k = 0; k < 3; k++) begin
                        idx = (m_ptr[o] + k) % 3;
                        if (el[idx] && din[idx] == o + 1) order.push_back(idx);
                    end
                end
                win = -1;
                foreach (order[j]) if (win < 0 && m_cnt[order[j]] == LIMIT) win = order[j];
                if (win < 0 && order.size() > 0) win = order[0];
                if (win >= 0) begin
                    g[win] = 1'b1;
                    m_sel[o] = win + 1;
                    m_ptr[o] = (win + 1) % 3;
                    ng++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                m_fail[i] = el[i] && !g[i];
                m_cnt[i] = m_fail[i] ? ((m_cnt[i] < LIMIT) ? m_cnt[i] + 1 : LIMIT) : 0;
                m_grant[i] = g[i];
            end
            if (nel == 0)         m_state = 0;
            else if (m_state == 0) m_state = 1;
            else if (ng > 0)      m_state = 1;
            else                  m_state = 2;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("cyc_grant", {5'b0, grant_local, grant_y, grant_x},
                  {5'b0, m_grant[2], m_grant[1], m_grant[0]});
            check("cyc_sel", {2'b0, sel_local, sel_y, sel_x},
                  {2'b0, 2'(m_sel[2]), 2'(m_sel[1]), 2'(m_sel[0])});
            check("cyc_fail", {5'b0, fail}, {5'b0, m_fail[2], m_fail[1], m_fail[0]});
            check("cyc_state", {6'b0, state}, 8'(m_state));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [2:0] gnt, input logic [5:0] sel,
                              input logic [2:0] fl, input logic [1:0] st);
        check({name, "_grant"}, {5'b0, grant_local, grant_y, grant_x}, {5'b0, gnt});
        check({name, "_sel"}, {2'b0, sel_local, sel_y, sel_x}, {2'b0, sel});
        check({name, "_fail"}, {5'b0, fail}, {5'b0, fl});
        check({name, "_state"}, {6'b0, state}, {6'b0, st});
    endtask

    task automatic clear_req();
        valid_x = 0; valid_y = 0; valid_local = 0;
        dest_x = 0; dest_y = 0; dest_local = 0;
    endtask

    initial begin
        rst_n = 0;
        clear_req();
        next_full_x = 0; next_full_y = 0; next_full_local = 0;
        tick(); tick();
        expect_out("reset", 3'b000, 6'b000000, 3'b000, 2'b00);

        // Single request X -> output Y.
        rst_n = 1;
        valid_x = 1; dest_x = 2'b10;
        tick();
        expect_out("single", 3'b001, 6'b000100, 3'b000, 2'b01);
        clear_req();
        tick();

        // dest=00 is ignored entirely.
        valid_x = 1; dest_x = 2'b00;
        tick();
        expect_out("nodest", 3'b000, 6'b000000, 3'b000, 2'b00);
        clear_req();

        // Three disjoint requests granted concurrently.
        valid_x = 1; dest_x = 2'b01;
        valid_y = 1; dest_y = 2'b10;
        valid_local = 1; dest_local = 2'b11;
        tick();
        expect_out("concurrent", 3'b111, 6'b111001, 3'b000, 2'b01);
        clear_req();
        tick();

        // Y -> output X while X is full, then release.
        valid_y = 1; dest_y = 2'b01; next_full_x = 1;
        tick();
        expect_out("full_c1", 3'b000, 6'b000000, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) tick();
        expect_out("stall", 3'b000, 6'b000000, 3'b010, 2'b10);
        next_full_x = 0;
        tick();
        expect_out("release", 3'b010, 6'b000010, 3'b000, 2'b01);
        clear_req();
        tick();

        // All three contend for output local: rotation X, Y, local, X.
        valid_x = 1; valid_y = 1; valid_local = 1;
        dest_x = 2'b11; dest_y = 2'b11; dest_local = 2'b11;
        tick();
        expect_out("rot1", 3'b001, 6'b010000, 3'b110, 2'b01);
        tick();
        expect_out("rot2", 3'b010, 6'b100000, 3'b100, 2'b01);
        tick();
        expect_out("rot3", 3'b100, 6'b110000, 3'b001, 2'b01);
        tick();
        expect_out("rot4", 3'b001, 6'b010000, 3'b010, 2'b01);

        // Reset pulse mid-arbitration; pointers return to X.
        rst_n = 0;
        tick();
        expect_out("midreset", 3'b000, 6'b000000, 3'b000, 2'b00);
        rst_n = 1;
        tick();
        expect_out("postreset", 3'b001, 6'b010000, 3'b110, 2'b01);
        clear_req();
        tick();

        // Starvation: local loses twice on output Y, then beats Y at pointer Y.
        next_full_y = 1;
        valid_x = 1; dest_x = 2'b10;
        valid_local = 1; dest_local = 2'b10;
        tick();
        expect_out("starve1", 3'b000, 6'b000000, 3'b101, 2'b01);
        next_full_y = 0;
        tick();
        expect_out("starve2", 3'b001, 6'b000100, 3'b100, 2'b01);
        valid_x = 0; dest_x = 2'b00;
        valid_y = 1; dest_y = 2'b10;
        tick();
        expect_out("starve3", 3'b100, 6'b001100, 3'b010, 2'b01);
        clear_req();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
